// File: rtl/mem_stage.sv
// Memory stage of the pipeline: EX/MEM register, word/byte data memory and MEM/WB register.
// Every register, and the data-memory write port, updates only on cycles without stall.
module mem_stage #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] ALUresult,
    input  logic [31:0] WriteData_MEM,
    input  logic [31:0] pc_MEM,
    input  logic [4:0]  RegDestination_MEM,
    input  logic [1:0]  MemtoReg_MEM,
    input  logic        WordOrByte_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic        RegWrite_MEM,
    output logic [31:0] ALUresult_EXE_MEM,
    output logic [4:0]  RegDestination_EXE_MEM,
    output logic        RegWrite_EXE_MEM,
    output logic [31:0] ALUresult_MEM_WB,
    output logic [4:0]  RegDestination_WB,
    output logic        RegWrite_WB
);

    localparam int AW = $clog2(DEPTH);

    // EX/MEM register
    logic [31:0] exAlu;
    logic [31:0] exWriteData;
    logic [31:0] exPc;
    logic [4:0]  exRegDest;
    logic [1:0]  exMemtoReg;
    logic        exWordOrByte;
    logic        exMemRead;
    logic        exMemWrite;
    logic        exRegWrite;

    // MEM/WB register
    logic [31:0] wbData;
    logic [4:0]  wbRegDest;
    logic        wbRegWrite;

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] wordIdx;
    logic [1:0]    byteSel;
    logic [31:0]   readWord;
    logic [7:0]    readByte;
    logic [31:0]   loadData;
    logic [31:0]   wbNext;

    assign wordIdx = exAlu[AW+1:2];
    assign byteSel = exAlu[1:0];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!reset_n) begin
            exAlu        <= '0;
            exWriteData  <= '0;
            exPc         <= '0;
            exRegDest    <= '0;
            exMemtoReg   <= '0;
            exWordOrByte <= 1'b0;
            exMemRead    <= 1'b0;
            exMemWrite   <= 1'b0;
            exRegWrite   <= 1'b0;
        end else if (!stall) begin
            exAlu        <= ALUresult;
            exWriteData  <= WriteData_MEM;
            exPc         <= pc_MEM;
            exRegDest    <= RegDestination_MEM;
            exMemtoReg   <= MemtoReg_MEM;
            exWordOrByte <= WordOrByte_MEM;
            // A flushed slot keeps its data fields but loses every side effect.
            exMemRead    <= MemRead_MEM  && !flush;
            exMemWrite   <= MemWrite_MEM && !flush;
            exRegWrite   <= RegWrite_MEM && !flush;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: no reset branch on the memory array; reset only cancels the pending store.
        if (reset_n && !stall && exMemWrite) begin
            if (exWordOrByte) begin
                mem[wordIdx] <= exWriteData;
            end else begin
                mem[wordIdx][{byteSel, 3'b000} +: 8] <= exWriteData[7:0];
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        readWord = '0;
        readByte = '0;
        loadData = '0;
        if (exMemRead) begin
            readWord = mem[wordIdx];
            case (byteSel)
                2'd0:    readByte = readWord[7:0];
                2'd1:    readByte = readWord[15:8];
                2'd2:    readByte = readWord[23:16];
                default: readByte = readWord[31:24];
            endcase
            loadData = exWordOrByte ? readWord : {{24{readByte[7]}}, readByte};
        end
        case (exMemtoReg)
            2'b01:   wbNext = loadData;
            2'b10:   wbNext = exPc + 32'd4;
            default: wbNext = exAlu;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wbData     <= '0;
            wbRegDest  <= '0;
            wbRegWrite <= 1'b0;
        end else if (!stall) begin
            wbData     <= wbNext;
            wbRegDest  <= exRegDest;
            wbRegWrite <= exRegWrite && (exRegDest != 5'd0);
        end
    end

    assign ALUresult_EXE_MEM      = exAlu;
    assign RegDestination_EXE_MEM = exRegDest;
    assign RegWrite_EXE_MEM       = exRegWrite;
    assign ALUresult_MEM_WB       = wbData;
    assign RegDestination_WB      = wbRegDest;
    assign RegWrite_WB            = wbRegWrite;

endmodule
